mem_arbiter: RTL and testbench

//  Shares one slow 128-bit memory port between the I-cache and D-cache miss/writeback interfaces.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow 128-bit line memory port between the I-cache and the D-cache.
//
// One cache is granted at a time. The granted request is captured into the registered mem_*
// outputs and held until mem_ready. The ready pulse is routed back to the granted side only.
// Sequence: StIdle -> StBusyI | StBusyD -> StRelease -> StIdle. The single StRelease cycle
// gives the cache FSM time to drop its request, so the same transaction is not issued twice.
//
// Build option (macro ARB_RR_EN):
//   defined   - round-robin selection; rr_last_q records the side granted last.
//   undefined - D has fixed priority. I is forced once STARVE_LIMIT consecutive D grants
//               have happened while I was waiting.
//
// Ports:
//   clk, rst_n                   clock; asynchronous active-low reset
//   I_read/I_write/I_addr/I_wdata I-cache request (read and write together forwards a write)
//   I_rdata, I_ready             I-cache response (I_rdata is mem_rdata; I_ready qualifies it)
//   D_*                          same set for the D-cache
//   mem_read/mem_write/mem_addr/mem_wdata  registered memory request
//   mem_rdata, mem_ready         memory response; mem_ready is a 1-cycle pulse
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StRelease} state_e;

  state_e              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic req_i, req_d;
  logic grant_i, grant_d;

  assign req_i = I_read | I_write;
  assign req_d = D_read | D_write;

`ifdef ARB_RR_EN
  localparam logic SideI = 1'b0;
  localparam logic SideD = 1'b1;

  logic rr_last_q, rr_last_d;

  // When both sides request, the side not granted last wins.
  assign grant_d = req_d & (~req_i | (rr_last_q == SideI));
  assign grant_i = req_i & ~grant_d;

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == StIdle) begin
      if (grant_d) begin
        rr_last_d = SideD;
      end else if (grant_i) begin
        rr_last_d = SideI;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= SideI;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  // Number of consecutive D grants made while I was waiting.
  logic [3:0] starve_q, starve_d;
  logic       force_i;

  assign force_i = req_i & (starve_q == StarveMax);
  assign grant_d = req_d & ~force_i;
  assign grant_i = req_i & ~grant_d;

  always_comb begin
    starve_d = starve_q;
    if (state_q == StIdle) begin
      if (grant_i) begin
        starve_d = '0;
      end else if (grant_d) begin
        if (!req_i) begin
          starve_d = '0;
        end else if (starve_q != StarveMax) begin
          starve_d = starve_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        // A simultaneous read+write is illegal; the write takes precedence.
        if (grant_d) begin
          state_d     = StBusyD;
          mem_write_d = D_write;
          mem_read_d  = D_read & ~D_write;
          mem_addr_d  = D_addr;
          mem_wdata_d = D_wdata;
        end else if (grant_i) begin
          state_d     = StBusyI;
          mem_write_d = I_write;
          mem_read_d  = I_read & ~I_write;
          mem_addr_d  = I_addr;
          mem_wdata_d = I_wdata;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready) begin
          state_d     = StRelease;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // mem_ready outside a busy state never reaches either cache.
  assign I_ready = (state_q == StBusyI) & mem_ready;
  assign D_ready = (state_q == StBusyD) & mem_ready;
  assign I_rdata = mem_rdata;
  assign D_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences
// and randomized transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int unsigned AW    = 28;
  localparam int unsigned DW    = 128;
  localparam int          LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          I_read, I_write, D_read, D_write;
  logic [AW-1:0] I_addr, D_addr, mem_addr;
  logic [DW-1:0] I_wdata, D_wdata, I_rdata, D_rdata, mem_wdata, mem_rdata;
  logic          I_ready, D_ready, mem_read, mem_write, mem_ready;

  mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I_read   (I_read),
    .I_write  (I_write),
    .I_addr   (I_addr),
    .I_wdata  (I_wdata),
    .I_rdata  (I_rdata),
    .I_ready  (I_ready),
    .D_read   (D_read),
    .D_write  (D_write),
    .D_addr   (D_addr),
    .D_wdata  (D_wdata),
    .D_rdata  (D_rdata),
    .D_ready  (D_ready),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ir, iw, dr, dw;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] iwd, dwd, rdata;
    int            lat;
    logic          exp_d, exp_rd, exp_wr;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Arbitration model: how many D grants in a row happened while I was waiting,
  // and which side was served last.
  int d_streak_while_i_waits;
  bit last_was_d;
  bit in_release;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit model_pick_d(input bit ri, input bit rd);
`ifdef ARB_RR_EN
    if (ri && rd) return !last_was_d;
    return rd;
`else
    if (ri && d_streak_while_i_waits >= LIMIT) return 1'b0;
    return rd;
`endif
  endfunction

  task automatic model_grant(input bit gave_d, input bit ri);
    last_was_d = gave_d;
    if (gave_d && ri) begin
      if (d_streak_while_i_waits < LIMIT) d_streak_while_i_waits++;
    end else begin
      d_streak_while_i_waits = 0;
    end
  endtask

  task automatic drop_all();
    I_read = 1'b0; I_write = 1'b0; D_read = 1'b0; D_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drop_all();
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d_streak_while_i_waits = 0;
    last_was_d = 1'b0;
    in_release = 1'b0;
  endtask

  // Waits up to 6 cycles for a grant; returns the number of negedges taken (0 = none).
  task automatic wait_grant(output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      @(negedge clk);
      n++;
      got = mem_read | mem_write;
    end
    if (!got) n = 0;
  endtask

  // Entered and left at a negedge.
  task automatic run_txn(input vec_t v);
    int            n;
    int            exp_lat;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    I_read = v.ir; I_write = v.iw; I_addr = v.ia; I_wdata = v.iwd;
    D_read = v.dr; D_write = v.dw; D_addr = v.da; D_wdata = v.dwd;
    exp_lat  = in_release ? 2 : 1;
    exp_addr = v.exp_d ? v.da : v.ia;
    exp_wd   = v.exp_d ? v.dwd : v.iwd;
    wait_grant(n);
    check("grant_seen", DW'(n != 0), DW'(1));
    if (n == 0) begin
      drop_all();
      in_release = 1'b0;
      return;
    end
    check("grant_latency", DW'(n), DW'(exp_lat));
    check("mem_addr", DW'(mem_addr), DW'(exp_addr));
    check("mem_read", DW'(mem_read), DW'(v.exp_rd));
    check("mem_write", DW'(mem_write), DW'(v.exp_wr));
    check("mem_wdata", mem_wdata, exp_wd);
    // The granted cache walks away mid-transaction; memory must still complete it.
    if (v.exp_d) begin
      D_read = 1'b0; D_write = 1'b0; D_addr = ~D_addr; D_wdata = ~D_wdata;
    end else begin
      I_read = 1'b0; I_write = 1'b0; I_addr = ~I_addr; I_wdata = ~I_wdata;
    end
    for (int k = 0; k < v.lat; k++) begin
      #1;
      check("ready_early_i", DW'(I_ready), DW'(0));
      check("ready_early_d", DW'(D_ready), DW'(0));
      @(negedge clk);
      check("mem_addr_hold", DW'(mem_addr), DW'(exp_addr));
    end
    mem_rdata = v.rdata;
    mem_ready = 1'b1;
    #1;
    check("ready_granted", DW'(v.exp_d ? D_ready : I_ready), DW'(1));
    check("ready_other", DW'(v.exp_d ? I_ready : D_ready), DW'(0));
    check("I_rdata", I_rdata, v.rdata);
    check("D_rdata", D_rdata, v.rdata);
    @(negedge clk);
    mem_ready = 1'b0;
    drop_all();
    check("release_rd", DW'(mem_read), DW'(0));
    check("release_wr", DW'(mem_write), DW'(0));
    in_release = 1'b1;
  endtask

  vec_t tbl[7];

  initial begin
    int            n;
    logic [4:0]    seq_d;
    vec_t          v;
    int            op_i, op_d;
    bit            ri, rd;

    rst_n = 1'b0;
    I_read = 1'b0; I_write = 1'b0; I_addr = '0; I_wdata = '0;
    D_read = 1'b0; D_write = 1'b0; D_addr = '0; D_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #1;
    check("rst_mem_read", DW'(mem_read), DW'(0));
    check("rst_mem_write", DW'(mem_write), DW'(0));
    check("rst_mem_addr", DW'(mem_addr), DW'(0));
    check("rst_mem_wdata", mem_wdata, DW'(0));
    check("rst_I_ready", DW'(I_ready), DW'(0));
    check("rst_D_ready", DW'(D_ready), DW'(0));
    do_reset();

    // ir iw dr dw ia da iwd dwd rdata lat exp_d exp_rd exp_wr
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 28'h0000010, 28'h0, 128'h0, 128'h0,
               {4{32'hA5A5A5A5}}, 5, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 28'h0, 28'h0001234, 128'h0, 128'h0,
               {4{32'h1234ABCD}}, 2, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 28'h0000020, 28'h0, {4{32'hCAFEF00D}}, 128'h0,
               128'h0, 0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 28'h0, 28'h0000055, 128'h0, {4{32'h5555AAAA}},
               128'h0, 1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 28'h0, 28'h0000077, 128'h0, {4{32'h77777777}},
               128'h0, 1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 28'h00000AB, 28'h0, {4{32'hDEADBEEF}}, 128'h0,
               128'h0, 2, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 28'h0000333, 28'h0000444, 128'h0, {4{32'h44444444}},
               {4{32'h0BADF00D}}, 3, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Simultaneous I read / D write: D first, then I right after the release cycle.
    do_reset();
    I_addr = 28'h0000111; D_addr = 28'h0000222; D_wdata = {4{32'h22222222}};
    I_read = 1'b1; D_write = 1'b1;
    @(negedge clk);
    check("t2_d_write", DW'(mem_write), DW'(1));
    check("t2_d_addr", DW'(mem_addr), DW'(28'h0000222));
    mem_ready = 1'b1;
    #1;
    check("t2_d_ready", DW'(D_ready), DW'(1));
    check("t2_i_ready", DW'(I_ready), DW'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    D_write = 1'b0;
    check("t2_release", DW'(mem_read | mem_write), DW'(0));
    @(negedge clk);
    check("t2_idle", DW'(mem_read | mem_write), DW'(0));
    @(negedge clk);
    check("t2_i_read", DW'(mem_read), DW'(1));
    check("t2_i_addr", DW'(mem_addr), DW'(28'h0000111));
    mem_ready = 1'b1;
    #1;
    check("t2_i_ready2", DW'(I_ready), DW'(1));
    @(negedge clk);
    mem_ready = 1'b0;
    drop_all();

    // Both sides held continuously: starvation escape (or alternation in round-robin).
    do_reset();
`ifdef ARB_RR_EN
    seq_d = 5'b10101;
`else
    seq_d = 5'b01111;
`endif
    I_addr = 28'h0000100; D_addr = 28'h0000200;
    I_read = 1'b1; D_read = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_grant(n);
      check("starve_grant_seen", DW'(n != 0), DW'(1));
      if (n == 0) break;
      check("starve_seq", DW'(mem_addr), DW'(seq_d[g] ? 28'h0000200 : 28'h0000100));
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    drop_all();
    repeat (2) @(negedge clk);

    // D_addr changes while busy: memory address must hold.
    do_reset();
    D_addr = 28'h0000001; D_read = 1'b1;
    @(negedge clk);
    D_addr = 28'h0000002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_addr_hold", DW'(mem_addr), DW'(28'h0000001));
    end
    mem_ready = 1'b1;
    #1;
    check("t5_d_ready", DW'(D_ready), DW'(1));
    @(negedge clk);
    mem_ready = 1'b0;
    drop_all();

    // Reset in the middle of an I transaction.
    do_reset();
    I_addr = 28'h0000ABC; I_wdata = {4{32'h12345678}}; I_write = 1'b1;
    @(negedge clk);
    check("t6_busy", DW'(mem_write), DW'(1));
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_write", DW'(mem_write), DW'(0));
    check("t6_rst_read", DW'(mem_read), DW'(0));
    check("t6_rst_addr", DW'(mem_addr), DW'(0));
    check("t6_rst_wdata", mem_wdata, DW'(0));
    check("t6_rst_i_ready", DW'(I_ready), DW'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    drop_all();
    rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("t6_no_i_ready", DW'(I_ready), DW'(0));
    check("t6_no_d_ready", DW'(D_ready), DW'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    check("t6_no_grant", DW'(mem_read | mem_write), DW'(0));

    // Randomized transactions against the model.
    do_reset();
    for (int it = 0; it < 80; it++) begin
      op_i = int'($urandom_range(0, 3));
      op_d = int'($urandom_range(0, 3));
      if (op_i == 0 && op_d == 0) op_d = 1;
      v.ir = op_i[0]; v.iw = op_i[1]; v.dr = op_d[0]; v.dw = op_d[1];
      v.ia = AW'($urandom); v.da = AW'($urandom);
      v.iwd = {$urandom, $urandom, $urandom, $urandom};
      v.dwd = {$urandom, $urandom, $urandom, $urandom};
      v.rdata = {$urandom, $urandom, $urandom, $urandom};
      v.lat = int'($urandom_range(0, 3));
      ri = v.ir | v.iw;
      rd = v.dr | v.dw;
      v.exp_d  = model_pick_d(ri, rd);
      v.exp_wr = v.exp_d ? v.dw : v.iw;
      v.exp_rd = (v.exp_d ? v.dr : v.ir) & ~v.exp_wr;
      model_grant(v.exp_d, ri);
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
